// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DISCARD
  } eth_state_e;

  localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;
  localparam logic [31:0] ETH_CRC_RESIDUE    = 32'h2144_DF1C;

endpackage

// File: rtl/eth_fcs_strip_buf.sv
// Four-byte delay line that holds back the FCS; only built when ETH_RX_FCS_STRIP_EN is defined.
`ifdef ETH_RX_FCS_STRIP_EN
module eth_fcs_strip_buf (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  logic [7:0] data_q [4];
  logic [3:0] vld_q;
  logic [7:0] out_q;
  logic       out_vld_q;

  // A byte leaves only when a fifth one arrives behind it; flush drops the held FCS.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) data_q[i] <= 8'h00;
      vld_q     <= 4'b0000;
      out_q     <= 8'h00;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= push_i && vld_q[3];
      if (push_i) begin
        if (vld_q[3]) out_q <= data_q[3];
        data_q[3] <= data_q[2];
        data_q[2] <= data_q[1];
        data_q[1] <= data_q[0];
        data_q[0] <= data_i;
        vld_q     <= {vld_q[2:0], 1'b1};
      end else if (flush_i) begin
        vld_q <= 4'b0000;
      end
    end
  end

  assign data_o  = out_q;
  assign valid_o = out_vld_q;

endmodule
`endif

// File: rtl/eth_rmii_rx_framer.sv
// RMII receive framer: preamble/SFD hunt, dibit-to-byte assembly and frame status.
// Define ETH_RX_FCS_STRIP_EN to drop the trailing 4 FCS bytes from the byte stream.
module eth_rmii_rx_framer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic        eth_clk,
  input  logic        rst_in_n,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  input  logic [31:0] crc_in,
  output logic        crc_active,
  output logic [1:0]  crc_dibit,
  output logic [7:0]  axiod,
  output logic        axiov,
  output logic        frame_done,
  output logic        frame_ok
);
  import eth_pkg::*;

  localparam int CW = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_FRAME_BYTES);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME_BYTES + 1);

  eth_state_e    state_q;
  logic [1:0]    dibit_cnt_q;
  logic [CW-1:0] byte_cnt_q;
  logic [5:0]    shift_q;
  logic          frame_done_q;
  logic          frame_ok_q;

  logic [7:0]    byte_d;
  logic          byte_done_d;
  logic          byte_keep_d;
  logic          end_cycle_d;

  always_comb begin
    byte_d      = {eth_rxd, shift_q};
    byte_done_d = (state_q == DATA) && eth_crsdv && (dibit_cnt_q == 2'd3);
    byte_keep_d = byte_done_d && (byte_cnt_q < CNT_MAX);
    end_cycle_d = (state_q == DATA) && !eth_crsdv;
  end

  assign crc_active = (state_q == DATA) && eth_crsdv;
  assign crc_dibit  = {eth_rxd[0], eth_rxd[1]};

  always_ff @(posedge eth_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= IDLE;
      dibit_cnt_q  <= 2'd0;
      byte_cnt_q   <= '0;
      shift_q      <= 6'd0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eth_crsdv && eth_rxd == ETH_PREAMBLE_DIBIT) state_q <= PREAMBLE;
        end
        PREAMBLE: begin
          if (!eth_crsdv) begin
            state_q <= IDLE;
          end else if (eth_rxd == ETH_SFD_DIBIT) begin
            state_q     <= DATA;
            dibit_cnt_q <= 2'd0;
            byte_cnt_q  <= '0;
          end else if (eth_rxd != ETH_PREAMBLE_DIBIT) begin
            state_q <= DISCARD;
          end
        end
        DATA: begin
          // The CRC stage has absorbed every dibit by the end cycle, so its output is final here.
          if (!eth_crsdv) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            frame_ok_q   <= (crc_in == ETH_CRC_RESIDUE) && (dibit_cnt_q == 2'd0) &&
                            (byte_cnt_q >= CNT_MIN) && (byte_cnt_q <= CNT_MAX);
          end else begin
            dibit_cnt_q <= dibit_cnt_q + 2'd1;
            shift_q     <= {eth_rxd, shift_q[5:2]};
            if (byte_done_d && byte_cnt_q != CNT_SAT) byte_cnt_q <= byte_cnt_q + CW'(1);
          end
        end
        DISCARD: begin
          if (!eth_crsdv) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;

`ifdef ETH_RX_FCS_STRIP_EN
  eth_fcs_strip_buf u_strip (
    .clk_i   (eth_clk),
    .rst_n_i (rst_in_n),
    .push_i  (byte_keep_d),
    .flush_i (end_cycle_d),
    .data_i  (byte_d),
    .data_o  (axiod),
    .valid_o (axiov)
  );
`else
  logic [7:0] axiod_q;
  logic       axiov_q;

  always_ff @(posedge eth_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      axiod_q <= 8'h00;
      axiov_q <= 1'b0;
    end else begin
      axiov_q <= byte_keep_d;
      if (byte_keep_d) axiod_q <= byte_d;
    end
  end

  assign axiod = axiod_q;
  assign axiov = axiov_q;

  logic unused_end_cycle;
  assign unused_end_cycle = end_cycle_d;
`endif

endmodule
